// File: rtl/scl_slave_monitor.sv
// -----------------------------------------------------------------------------
// scl_slave_monitor
//   Slave-side SCL/SDA front end sitting between the open-drain pads and the
//   slave byte/bit FSM. Synchronizes and glitch-filters both lines, flags SCL
//   edges and START/STOP conditions, tracks bus occupancy and stretches SCL
//   (holds it low) while the slave core asks for more time.
//
// Parameters
//   FILT_LEN   consecutive stable clocks before a filtered level changes (0 = bypass)
//   SETUP_CYC  clocks SCL stays held low after scl_wait drops (SDA setup time)
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   en             in   block enable; 0 releases the bus and clears status
//   scl_wait       in   slave core stretch request, honoured only while SCL low
//   scl_i          in   SCL pad input
//   sda_i          in   SDA pad input
//   scl_o          out  SCL pad drive (0 = pull low, 1 = release), registered
//   scl_f          out  filtered SCL level
//   sda_f          out  filtered SDA level
//   scl_rise       out  1-cycle pulse on filtered SCL 0->1
//   scl_fall       out  1-cycle pulse on filtered SCL 1->0
//   start_det      out  1-cycle pulse on START / repeated START
//   stop_det       out  1-cycle pulse on STOP
//   bus_busy       out  high from START until STOP
//   scl_stretching out  high while this block drives SCL low
// -----------------------------------------------------------------------------
module scl_slave_monitor #(
    parameter int unsigned FILT_LEN  = 3,
    parameter int unsigned SETUP_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic scl_wait,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic scl_stretching
);

    localparam int unsigned FCW   = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned FLAST = (FILT_LEN > 0) ? FILT_LEN - 1 : 0;
    localparam int unsigned SCW   = (SETUP_CYC > 2) ? $clog2(SETUP_CYC) : 1;
    localparam int unsigned SLAST = (SETUP_CYC > 0) ? SETUP_CYC - 1 : 0;

    // Line indices inside the packed {sda, scl} vectors
    localparam int unsigned L_SCL = 0;
    localparam int unsigned L_SDA = 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_SETUP   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]     sync1;
    logic [1:0]     filt_q;
    logic [1:0]     filt_nxt;

    logic           scl_q_c;
    logic           scl_n_c;
    logic           sda_q_c;
    logic           sda_n_c;
    logic           rise_c;
    logic           fall_c;
    logic           start_c;
    logic           stop_c;

    logic [1:0]     state_q;
    logic [1:0]     state_nxt;
    logic [SCW-1:0] scnt_q;
    logic [SCW-1:0] scnt_nxt;
    logic           stretch_nxt;

    // First synchronizer stage; runs regardless of en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
        end else begin
            sync1 <= {sda_i, scl_i};
        end
    end

    generate
        if (FILT_LEN == 0) begin : g_bypass
            // Filtered register doubles as the second synchronizer stage
            assign filt_nxt = sync1;
        end else begin : g_filt
            logic [1:0]     sync2;
            logic [FCW-1:0] cnt [2];

            // Second sync stage plus per-line stability counters
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync2 <= 2'b11;
                    for (int i = 0; i < 2; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    sync2 <= sync1;
                    for (int i = 0; i < 2; i++) begin
                        if (sync2[i] != filt_q[i]) begin
                            if (cnt[i] == FCW'(FLAST)) begin
                                cnt[i] <= '0;
                            end else begin
                                cnt[i] <= cnt[i] + FCW'(1);
                            end
                        end else begin
                            cnt[i] <= '0;
                        end
                    end
                end
            end

            // Level follows sync only after FILT_LEN consecutive differing clocks
            always_comb begin
                filt_nxt = filt_q;
                for (int i = 0; i < 2; i++) begin
                    if ((sync2[i] != filt_q[i]) && (cnt[i] == FCW'(FLAST))) begin
                        filt_nxt[i] = sync2[i];
                    end
                end
            end
        end
    endgenerate

    // Filtered levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 2'b11;
        end else begin
            filt_q <= filt_nxt;
        end
    end

    assign scl_f = filt_q[L_SCL];
    assign sda_f = filt_q[L_SDA];

    // Events compare the held filtered value with the one being loaded, so
    // each pulse lines up with the filtered level change itself
    assign scl_q_c = filt_q[L_SCL];
    assign scl_n_c = filt_nxt[L_SCL];
    assign sda_q_c = filt_q[L_SDA];
    assign sda_n_c = filt_nxt[L_SDA];

    assign rise_c  = ~scl_q_c &  scl_n_c;
    assign fall_c  =  scl_q_c & ~scl_n_c;
    // SCL must be high on both sides, so a simultaneous SCL change suppresses it
    assign start_c =  scl_q_c &  scl_n_c &  sda_q_c & ~sda_n_c;
    assign stop_c  =  scl_q_c &  scl_n_c & ~sda_q_c &  sda_n_c;

    // Status pulses and bus occupancy; en=0 silences everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            bus_busy  <= 1'b0;
        end else begin
            scl_rise  <= en & rise_c;
            scl_fall  <= en & fall_c;
            start_det <= en & start_c;
            stop_det  <= en & stop_c;
            bus_busy  <= en & (start_c | (bus_busy & ~stop_c));
        end
    end

    // Stretch FSM state register with registered pad drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            scnt_q         <= '0;
            scl_o          <= 1'b1;
            scl_stretching <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            scnt_q         <= scnt_nxt;
            scl_o          <= ~stretch_nxt;
            scl_stretching <= stretch_nxt;
        end
    end

    // Stretch FSM next state
    always_comb begin
        state_nxt   = state_q;
        scnt_nxt    = scnt_q;
        stretch_nxt = 1'b0;

        if (!en || stop_det) begin
            state_nxt = ST_IDLE;
            scnt_nxt  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A request made while SCL is high waits for the low phase
                    if (scl_wait && !scl_f) begin
                        state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!scl_wait) begin
                        scnt_nxt  = '0;
                        state_nxt = (SETUP_CYC == 0) ? ST_RELEASE : ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (scnt_q == SCW'(SLAST)) begin
                        state_nxt = ST_RELEASE;
                    end else begin
                        scnt_nxt = scnt_q + SCW'(1);
                    end
                end
                ST_RELEASE: begin
                    // Wait for SCL to really go high so one low phase is
                    // never stretched twice, even if another device holds it
                    if (scl_f) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        stretch_nxt = (state_nxt == ST_HOLD) || (state_nxt == ST_SETUP);
    end

endmodule
